// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: interrupt controller for the system timer's sources.
// Rising edges on irq_src_i latch into a pending register. Pending sources
// are masked by IRQ_EN and arbitrated by IRQ_PRIO. The winner is presented
// on irq_o/irq_id_o. Claim happens through a read of IRQ_CLAIM and complete
// through a write of IRQ_CLAIM.
//
// Bus handshake: there is no back-pressure. A write is accepted on every
// clock edge where we_i is high, with per-byte enables in sel_i. A read is
// accepted on every edge where rd_i is high. Its data appears on data_o
// after that edge and is held until the next rd_i. Any side effect of a
// read (a claim) happens at the rd_i edge.
module timer_irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      waddr_i,
  input  logic [31:0]     data_i,
  input  logic [3:0]      sel_i,
  input  logic            we_i,
  input  logic [7:0]      raddr_i,
  input  logic            rd_i,
  output logic [31:0]     data_o,
  input  logic [NSRC-1:0] irq_src_i,
  output logic            irq_o,
  output logic [2:0]      irq_id_o
);

  localparam logic [7:0] A_EN    = 8'h00;
  localparam logic [7:0] A_PEND  = 8'h04;
  localparam logic [7:0] A_PRIO  = 8'h08;
  localparam logic [7:0] A_CLAIM = 8'h0C;
  localparam logic [7:0] A_OVR   = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PEND    = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   en_src_q, en_src_d;
  logic              gen_q, gen_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [2*NSRC-1:0] prio_q, prio_d;
  logic [15:0]       ovr_q, ovr_d;
  logic [NSRC-1:0]   src_q, src_d;
  logic              arm_q, arm_d;
  logic [2:0]        id_q, id_d;
  logic [31:0]       data_q, data_d;

  logic              wr_en, wr_pend, wr_prio, wr_claim, wr_ovr;
  logic              rd_claim, complete;
  logic [31:0]       wmask;
  logic [NSRC-1:0]   rise, w1c, claim_clr, id_onehot, cand;
  logic              id_cand, ovr_hit;
  logic              win_vld;
  logic [2:0]        win_id;
  logic [1:0]        win_prio;
  logic [31:0]       rdata;
  logic              unused_data_bits;

  assign wr_en    = we_i && (waddr_i == A_EN);
  assign wr_pend  = we_i && (waddr_i == A_PEND);
  assign wr_prio  = we_i && (waddr_i == A_PRIO);
  assign wr_claim = we_i && (waddr_i == A_CLAIM);
  assign wr_ovr   = we_i && (waddr_i == A_OVR);
  assign rd_claim = rd_i && (raddr_i == A_CLAIM) && (state_q == ST_PEND);
  assign complete = wr_claim && sel_i[0] && (data_i[2:0] == id_q);
  assign wmask    = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign cand     = pend_q & en_src_q;
  assign unused_data_bits = ^data_i[30:2*NSRC];

  // Byte-masked updates of the enable and priority registers.
  always_comb begin
    en_src_d = en_src_q;
    gen_d    = gen_q;
    prio_d   = prio_q;
    if (wr_en) begin
      if (sel_i[0]) en_src_d = data_i[NSRC-1:0];
      if (sel_i[3]) gen_d = data_i[31];
    end
    if (wr_prio) begin
      prio_d = (prio_q & ~wmask[2*NSRC-1:0]) | (data_i[2*NSRC-1:0] & wmask[2*NSRC-1:0]);
    end
  end

  // Edge detection, pending set/clear and overrun counting.
  // arm_q is low for the first cycle out of reset, so a level that was held
  // high across reset only loads src_q and is not taken as a fresh edge.
  always_comb begin
    src_d = irq_src_i;
    arm_d = 1'b1;
    rise  = arm_q ? (irq_src_i & ~src_q) : '0;
    w1c   = (wr_pend && sel_i[0]) ? data_i[NSRC-1:0] : '0;
    for (int k = 0; k < NSRC; k++) begin
      id_onehot[k] = (id_q == 3'(k));
    end
    claim_clr = rd_claim ? id_onehot : '0;
    id_cand   = |(cand & id_onehot);
    // A new edge beats a same-cycle W1C or claim and is not an overrun then.
    pend_d  = (pend_q & ~w1c & ~claim_clr) | rise;
    ovr_hit = |(rise & pend_q & ~w1c & ~claim_clr);
    ovr_d   = ovr_q;
    if (wr_ovr && (|sel_i)) begin
      ovr_d = '0;
    end else if (ovr_hit && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end
  end

  // Arbitration: highest priority value wins; ties go to the lowest index.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (cand[k] && (!win_vld || (prio_q[2*k +: 2] > win_prio))) begin
        win_vld  = 1'b1;
        win_id   = 3'(k);
        win_prio = prio_q[2*k +: 2];
      end
    end
  end

  // Presentation FSM next state and winner latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (gen_q && win_vld) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!gen_q) begin
          state_d = ST_IDLE;
        end else begin
          id_d    = win_id;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!gen_q) begin
          state_d = ST_IDLE;
        end else if (rd_claim) begin
          state_d = ST_SERVICE;
        end else if (!id_cand) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux. data_o only updates on a read strobe.
  always_comb begin
    rdata = '0;
    case (raddr_i)
      A_EN:    rdata = {gen_q, {(31-NSRC){1'b0}}, en_src_q};
      A_PEND:  rdata = {{(32-NSRC){1'b0}}, pend_q};
      A_PRIO:  rdata = {{(32-2*NSRC){1'b0}}, prio_q};
      A_CLAIM: rdata = (state_q == ST_PEND) ? {1'b1, 28'b0, id_q} : '0;
      A_OVR:   rdata = {16'b0, ovr_q};
      default: rdata = '0;
    endcase
    data_d = rd_i ? rdata : data_q;
  end

  // State and register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_src_q <= '0;
      gen_q    <= 1'b0;
      pend_q   <= '0;
      prio_q   <= '0;
      ovr_q    <= '0;
      src_q    <= '0;
      arm_q    <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      en_src_q <= en_src_d;
      gen_q    <= gen_d;
      pend_q   <= pend_d;
      prio_q   <= prio_d;
      ovr_q    <= ovr_d;
      src_q    <= src_d;
      arm_q    <= arm_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign data_o   = data_q;
  assign irq_o    = (state_q == ST_PEND);
  assign irq_id_o = id_q;

endmodule
